// File: rtl/wormhole_output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin among head flits, packet lock
// from head to tail, and downstream credit gating of every transfer.
module wormhole_output_arbiter #(
    parameter int N_IN       = 4,
    parameter int CREDIT_MAX = 4,
    parameter int CW         = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_IN-1:0] req,
    input  logic [N_IN-1:0] head,
    input  logic [N_IN-1:0] tail,
    input  logic            credit_in,
    output logic [N_IN-1:0] gnt,
    output logic            xfer,
    output logic            locked,
    output logic [1:0]      owner,
    output logic [CW-1:0]   credit,
    output logic            credit_err
);

    typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [1:0]      owner_r, owner_nxt_s;
    logic [1:0]      rr_ptr_r, rr_ptr_nxt_s;
    logic [CW-1:0]   credit_r;
    logic            credit_err_r;
    logic [N_IN-1:0] eligible_s;
    logic [N_IN-1:0] gnt_s;
    logic            can_send_s;
    logic            found_s;
    logic [1:0]      winner_s;
    logic [1:0]      idx_s;
    logic            xfer_s;

    assign eligible_s = req & head;
    assign can_send_s = en & (credit_r != {CW{1'b0}});

    // Round-robin search: first eligible head flit at or after rr_ptr.
    always_comb begin
        found_s  = 1'b0;
        winner_s = 2'd0;
        idx_s    = 2'd0;
        for (int k = 0; k < N_IN; k++) begin
            idx_s = 2'((int'(rr_ptr_r) + k) % N_IN);
            if (!found_s && eligible_s[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Zero-latency grant; a locked port only ever serves its owner.
    always_comb begin
        gnt_s = {N_IN{1'b0}};
        if (rst_n && can_send_s) begin
            if (state_r == LOCKED) begin
                gnt_s[owner_r] = req[owner_r];
            end else if (found_s) begin
                gnt_s[winner_s] = 1'b1;
            end else begin
                gnt_s = {N_IN{1'b0}};
            end
        end else begin
            gnt_s = {N_IN{1'b0}};
        end
    end

    assign xfer_s = |gnt_s;

    // Lock and pointer next-state; only a transfer can move either.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (xfer_s && tail[winner_s]) begin
                    rr_ptr_nxt_s = 2'((int'(winner_s) + 1) % N_IN);
                end else if (xfer_s) begin
                    state_nxt_s = LOCKED;
                    owner_nxt_s = winner_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (xfer_s && tail[owner_r]) begin
                    state_nxt_s  = IDLE;
                    rr_ptr_nxt_s = 2'((int'(owner_r) + 1) % N_IN);
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            owner_r  <= 2'd0;
            rr_ptr_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    // Downstream credit counter; a return at full credit is a protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_r     <= CW'(CREDIT_MAX);
            credit_err_r <= 1'b0;
        end else begin
            case ({credit_in, xfer_s})
                2'b10: begin
                    if (credit_r == CW'(CREDIT_MAX)) begin
                        credit_err_r <= 1'b1;
                    end else begin
                        credit_r <= credit_r + CW'(1);
                    end
                end
                2'b01:   credit_r <= credit_r - CW'(1);
                default: credit_r <= credit_r;
            endcase
        end
    end

    assign gnt        = gnt_s;
    assign xfer       = xfer_s;
    assign locked     = (state_r == LOCKED);
    assign owner      = owner_r;
    assign credit     = credit_r;
    assign credit_err = credit_err_r;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Directed bench for wormhole_output_arbiter: a packet-level model is compared
// against the DUT every cycle, plus hand-computed checks of the directed scenarios.
module tb_wormhole_output_arbiter;

    localparam int N = 4;
    localparam int CMAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'd0, head = 4'd0, tail = 4'd0;
    logic       credit_in = 1'b0;
    logic [3:0] gnt;
    logic       xfer, locked, credit_err;
    logic [1:0] owner;
    logic [2:0] credit;

    int checks = 0;
    int failures = 0;

    wormhole_output_arbiter #(.N_IN(4), .CREDIT_MAX(4), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .head(head), .tail(tail),
        .credit_in(credit_in), .gnt(gnt), .xfer(xfer), .locked(locked),
        .owner(owner), .credit(credit), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    // Packet-level model: who holds the port, whose turn it is, credits left.
    logic m_locked;
    int   m_owner, m_ptr, m_credit;
    logic m_err;

    function automatic logic [3:0] model_gnt();
        logic [3:0] g;
        int order[$];
        g = 4'd0;
        if (!rst_n || !en || m_credit == 0) return g;
        if (m_locked) begin
            g[m_owner] = req[m_owner];
            return g;
        end
        for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
        foreach (order[j]) begin
            if (req[order[j]] && head[order[j]]) begin
                g[order[j]] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_locked <= 1'b0; m_owner <= 0; m_ptr <= 0; m_credit <= CMAX; m_err <= 1'b0;
        end else begin
            logic [3:0] g;
            int w, nc;
            g = model_gnt();
            w = onehot_idx(g);
            nc = m_credit + int'(credit_in) - int'(g != 4'd0);
            if (nc > CMAX) begin
                nc = CMAX;
                m_err <= 1'b1;
            end
            m_credit <= nc;
            if (g != 4'd0) begin
                if (m_locked && tail[m_owner]) begin
                    m_locked <= 1'b0; m_ptr <= (m_owner + 1) % N;
                end else if (!m_locked && tail[w]) begin
                    m_ptr <= (w + 1) % N;
                end else if (!m_locked) begin
                    m_locked <= 1'b1; m_owner <= w;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] eg;
        eg = model_gnt();
        chk("model_gnt", int'(gnt), int'(eg));
        chk("model_xfer", int'(xfer), int'(eg != 4'd0));
        chk("model_locked", int'(locked), int'(m_locked));
        if (m_locked) chk("model_owner", int'(owner), m_owner);
        chk("model_credit", int'(credit), m_credit);
        chk("model_err", int'(credit_err), int'(m_err));
        chk("onehot", int'($countones(gnt) <= 1), 1);
    end

    task automatic cyc(input logic [3:0] r, input logic [3:0] h, input logic [3:0] t,
                       input logic e, input logic c);
        @(posedge clk);
        #1;
        req = r; head = h; tail = t; en = e; credit_in = c;
        @(negedge clk);
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_credit", int'(credit), 4);
        chk("reset_locked", int'(locked), 0);
        chk("reset_gnt", int'(gnt), 0);

        // 1: single-flit packets from everybody rotate 0,1,2,3 then credits run out
        cyc(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0); chk("t1_g0", int'(gnt), 4'b0001);
        cyc(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0); chk("t1_g1", int'(gnt), 4'b0010);
        cyc(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0); chk("t1_g2", int'(gnt), 4'b0100);
        cyc(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0); chk("t1_g3", int'(gnt), 4'b1000);
        cyc(4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0); chk("t1_g4", int'(gnt), 0);
        chk("t1_credit0", int'(credit), 0);

        for (int i = 0; i < 4; i++) cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);

        // 2: 4-flit packet from input 2 holds the port against input 0's head
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0); chk("t2_f1", int'(gnt), 4'b0100);
        chk("t2_credit", int'(credit), 4);
        cyc(4'b0101, 4'b0001, 4'b0000, 1'b1, 1'b1); chk("t2_f2", int'(gnt), 4'b0100);
        chk("t2_lock2", int'(locked), 1); chk("t2_own2", int'(owner), 2);
        cyc(4'b0101, 4'b0001, 4'b0000, 1'b1, 1'b1); chk("t2_f3", int'(gnt), 4'b0100);
        chk("t2_own3", int'(owner), 2);
        cyc(4'b0101, 4'b0001, 4'b0100, 1'b1, 1'b1); chk("t2_f4", int'(gnt), 4'b0100);
        cyc(4'b1001, 4'b1001, 4'b1001, 1'b1, 1'b1); chk("t2_in3_after", int'(gnt), 4'b1000);
        chk("t2_unlocked", int'(locked), 0);
        cyc(4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0); chk("t2_in0", int'(gnt), 4'b0001);

        // 3: packet from input 1 drains credits, then stalls until a credit returns
        cyc(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0); chk("t3_head", int'(gnt), 4'b0010);
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc(4'b1111, 4'b1101, 4'b0000, 1'b1, 1'b0); chk("t3_stall", int'(gnt), 0);
        chk("t3_credit0", int'(credit), 0); chk("t3_own", int'(owner), 1);
        cyc(4'b1111, 4'b1101, 4'b0000, 1'b1, 1'b1); chk("t3_stall2", int'(gnt), 0);
        cyc(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0); chk("t3_resume", int'(gnt), 4'b0010);
        chk("t3_credit1", int'(credit), 1);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0); chk("t3_credit_back0", int'(credit), 0);

        // 4: simultaneous xfer+credit_in holds, overflow sets sticky error
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        cyc(4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1); chk("t4_gnt", int'(gnt), 4'b0100);
        chk("t4_credit_pre", int'(credit), 2);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1); chk("t4_credit_same", int'(credit), 2);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b1); chk("t4_credit_full", int'(credit), 4);
        chk("t4_err0", int'(credit_err), 0);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0); chk("t4_err1", int'(credit_err), 1);
        chk("t4_credit_hold", int'(credit), 4);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0); chk("t4_err_sticky", int'(credit_err), 1);

        // 5: en=0 mid-packet freezes the port, then the same owner resumes
        cyc(4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0); chk("t5_head", int'(gnt), 4'b1000);
        cyc(4'b1001, 4'b0001, 4'b0000, 1'b1, 1'b0); chk("t5_body", int'(gnt), 4'b1000);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1001, 4'b1001, 4'b0000, 1'b0, 1'b0);
            chk("t5_dis_gnt", int'(gnt), 0);
            chk("t5_dis_own", int'(owner), 3);
        end
        cyc(4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0); chk("t5_resume", int'(gnt), 4'b1000);

        // 6: async reset mid-packet drops lock and restores credits immediately
        cyc(4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0); chk("t6_head", int'(gnt), 4'b0001);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_locked", int'(locked), 0);
        chk("t6_rst_gnt", int'(gnt), 0);
        chk("t6_rst_credit", int'(credit), 4);
        req = 4'd0; head = 4'd0; tail = 4'd0; credit_in = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0); chk("t6_first", int'(gnt), 4'b0001);
        cyc(4'd0, 4'd0, 4'd0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
